// File: rtl/timebase_ctrl_if.sv
// Configuration handshake between the run-control master and the timebase:
// the master offers a half-period/phase-step pair and holds it until ready is seen.
interface timebase_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_half;
  logic [15:0]      cfg_step;
  logic             cfg_ready;

  modport master (output cfg_valid, cfg_half, cfg_step, input  cfg_ready);
  modport slave  (input  cfg_valid, cfg_half, cfg_step, output cfg_ready);
endinterface

// File: rtl/timebase_ctrl.sv
// Board timebase: divides CLK_IN into a 50% duty CLK with a tick per rise and
// a four-phase State sequence inside each high half, under start/pause/stop control.
module timebase_ctrl #(
  parameter int CNT_W    = 32,
  parameter int DEF_HALF = 25000000,
  parameter int DEF_STEP = 500
) (
  input  logic       CLK_IN,
  input  logic       RST,
  input  logic       cmd_start,
  input  logic       cmd_pause,
  input  logic       cmd_stop,
  timebase_ctrl_if.slave cfg,
  output logic       CLK,
  output logic       tick,
  output logic [1:0] State,
  output logic [1:0] run_state,
  output logic       busy
);
  localparam int PW = CNT_W + 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } fsm_t;

  fsm_t             fsm;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half_reg;
  logic [15:0]      step_reg;
  logic             ready_q;

  logic [PW-1:0] cnt_x, th1, th2, th3;
  logic [1:0]    phase_nxt;
  logic          at_wrap;
  logic          do_start;

  assign cfg.cfg_ready = ready_q;
  assign at_wrap       = (cnt == half_reg - CNT_W'(1));
  // start only wins when no higher-priority command is present
  assign do_start      = cmd_start & ~cmd_pause & ~cmd_stop;

  // widened thresholds so 3*step never wraps against the counter
  always_comb begin
    cnt_x     = PW'(cnt);
    th1       = PW'(step_reg);
    th2       = th1 << 1;
    th3       = th1 + th2;
    phase_nxt = State;
    if (cnt_x == th1) phase_nxt = 2'b01;
    if (cnt_x == th2) phase_nxt = 2'b10;
    if (cnt_x == th3) phase_nxt = 2'b11;
  end

  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) begin
      fsm       <= S_IDLE;
      cnt       <= '0;
      CLK       <= 1'b0;
      State     <= 2'b00;
      tick      <= 1'b0;
      ready_q   <= 1'b1;
      run_state <= S_IDLE;
      busy      <= 1'b0;
      half_reg  <= CNT_W'(DEF_HALF);
      step_reg  <= 16'(DEF_STEP);
    end else begin
      tick <= 1'b0;
      if (cfg.cfg_valid && ready_q) begin
        half_reg <= (cfg.cfg_half < CNT_W'(2)) ? CNT_W'(2) : cfg.cfg_half;
        step_reg <= (cfg.cfg_step == 16'd0) ? 16'd1 : cfg.cfg_step;
      end
      case (fsm)
        S_IDLE: begin
          cnt   <= '0;
          CLK   <= 1'b0;
          State <= 2'b00;
          if (do_start) begin
            fsm       <= S_RUN;
            run_state <= S_RUN;
            busy      <= 1'b1;
            ready_q   <= 1'b0;
          end
        end
        S_RUN: begin
          if (cmd_stop) begin
            fsm       <= S_IDLE;
            run_state <= S_IDLE;
            busy      <= 1'b0;
            ready_q   <= 1'b1;
            cnt       <= '0;
            CLK       <= 1'b0;
            State     <= 2'b00;
          end else if (cmd_pause) begin
            fsm       <= S_PAUSE;
            run_state <= S_PAUSE;
          end else begin
            if (at_wrap) begin
              cnt <= '0;
              CLK <= ~CLK;
              if (!CLK) begin
                State <= 2'b00;
                tick  <= 1'b1;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
            // phases only advance in the high half; the wrap edge may still hit one
            if (CLK) State <= phase_nxt;
          end
        end
        S_PAUSE: begin
          if (cmd_stop) begin
            fsm       <= S_IDLE;
            run_state <= S_IDLE;
            busy      <= 1'b0;
            ready_q   <= 1'b1;
            cnt       <= '0;
            CLK       <= 1'b0;
            State     <= 2'b00;
          end else if (do_start) begin
            fsm       <= S_RUN;
            run_state <= S_RUN;
          end
        end
        default: begin
          fsm       <= S_IDLE;
          run_state <= S_IDLE;
          busy      <= 1'b0;
          ready_q   <= 1'b1;
        end
      endcase
    end
  end
endmodule
